rainbow_hue_sequencer: RTL and testbench
========================================

Name: rainbow_hue_sequencer

Overview:
- Upstream stage of the RGB rainbow blender on the Tang Nano LED.
- Walks the 6-entry hue wheel and, for each transition, supplies the blender with a past base color, a future base color and a future-weight that ramps 0..N_STEPS-1.
- The downstream blender converts this triple into a time-dithered LED drive.
- Colors are active-low 3-bit codes, {R,B,G} MSB..LSB: RED 011, YELLOW 010, GREEN 110, CYAN 100, BLUE 101, MAGENTA 001.

Parameters:
- TICKS_PER_US, 12: clk ticks per microsecond.
- STEP_US, 10000: microseconds per weight step.
- N_STEPS, 32: weight steps per base-color transition; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = sequencer runs; 0 = prescaler cleared, outputs frozen
- hold  in  1  1 = prescaler paused, count retained (downstream backpressure)
- dir  in  1  0 = forward (RED->YELLOW->...), 1 = reverse
- restart  in  1  single-cycle request to return to RED, weight 0
- p_color  out  3  past base color
- f_color  out  3  future base color
- f_weight  out  $clog2(N_STEPS)  future weight; 0 = all past
- step_pulse  out  1  one-cycle strobe on every output update
- rev_count  out  8  completed full wheel revolutions, wraps 255->0

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: idx=0, dir_q=0, f_weight=0, p_color=011, f_color=010, step_pulse=0, rev_count=0, prescaler=0.
- Prescaler:
  - Counts 0..TICKS_PER_US*STEP_US-1 while enable=1 and hold=0.
  - Terminal count produces tick, and the count wraps to 0 in the same cycle.
  - hold=1 freezes the count; no tick.
  - enable=0 clears the count to 0 and suppresses tick; hold is ignored.
- Hue index and color outputs:
  - idx is 0..5; p_color = wheel[idx].
  - Forward next index is (idx+1) mod 6; reverse next index is (idx+5) mod 6.
  - f_color = wheel[next index], computed from the latched dir_q.
  - p_color and f_color are registered and updated together with idx and dir_q.
- On tick, when f_weight < N_STEPS-1:
  - f_weight increments.
  - step_pulse=1 in the cycle the new value is visible.
- On tick, when f_weight == N_STEPS-1 (boundary):
  - f_weight <= 0.
  - idx <= next index, computed with the old dir_q.
  - dir_q <= dir.
  - p_color and f_color are recomputed from the new idx and new dir_q.
  - step_pulse=1.
- dir is sampled only at a boundary or on restart. A mid-transition change of dir takes effect at the next boundary, so the output never jumps.
- rev_count increments when idx moves 5->0 (forward) or 0->5 (reverse). Wrap is modulo 256.
- restart:
  - Sets idx=0, f_weight=0, prescaler=0, dir_q<=dir.
  - Sets p_color=011 and f_color = forward ? 010 : 001.
  - Asserts step_pulse=1 for one cycle.
  - rev_count is unchanged.
  - Priority over a coincident tick; the tick is discarded.
  - Honoured even when enable=0 or hold=1.
- Reset asserted mid-operation returns every register to its reset value immediately; it is not qualified by clk.
- step_pulse is never asserted for two consecutive cycles unless restart is held high. If restart is held, each cycle re-applies the restart.

Test Plan (TICKS_PER_US=1, STEP_US=4, N_STEPS=4):
1. Release rst_n, then enable=1, hold=0, dir=0 -> first step_pulse 4 clk after enable with f_weight=1; step_pulses spaced exactly 4 clk; p/f stay 011/010 until the 4th step.
2. Run 4 steps (16 clk) -> at the boundary f_weight=0, p_color=010, f_color=110; after 24 steps p_color=011, f_color=010 and rev_count=1.
3. Set dir=1 at f_weight=2 during the RED->YELLOW transition -> f_color stays 010 until the boundary; then p_color=010, f_color=011; the next boundary gives p_color=011, f_color=001 (wheel[5]), with no rev_count change until idx moves 0->5.
4. hold=1 for 10 clk with prescaler at 2 -> no step_pulse during hold; the next step_pulse arrives 2 clk after hold drops. enable=0 instead -> the next step_pulse arrives 4 clk after enable returns.
5. Assert restart in the same cycle as a tick, with idx=3, f_weight=2 -> p_color=011, f_weight=0, single step_pulse, rev_count unchanged; the next step_pulse arrives 4 clk later.
6. Drop rst_n asynchronously mid-step (between clk edges) -> outputs go to reset values before the next clk edge; no step_pulse while rst_n=0.

Source files
------------

// File: rtl/rainbow_hue_sequencer_if.sv
// Control and colour-triple bundle between the hue sequencer and its environment.
// The slave side is the sequencer; the master side drives the controls and reads the triple.
interface rainbow_hue_sequencer_if #(
    parameter int N_STEPS = 32
);
    localparam int W = $clog2(N_STEPS);

    logic         enable;
    logic         hold;
    logic         dir;
    logic         restart;
    logic [2:0]   p_color;
    logic [2:0]   f_color;
    logic [W-1:0] f_weight;
    logic         step_pulse;
    logic [7:0]   rev_count;

    modport master (
        output enable, hold, dir, restart,
        input  p_color, f_color, f_weight, step_pulse, rev_count
    );

    modport slave (
        input  enable, hold, dir, restart,
        output p_color, f_color, f_weight, step_pulse, rev_count
    );
endinterface

// File: rtl/rainbow_hue_sequencer.sv
// Hue-wheel sequencer: emits past/future base colours and a ramping future weight
// for the downstream time-dithering blender, paced by a microsecond-based prescaler.
module rainbow_hue_sequencer #(
    parameter int TICKS_PER_US = 12,
    parameter int STEP_US      = 10000,
    parameter int N_STEPS      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rainbow_hue_sequencer_if.slave bus
);
    localparam int W     = $clog2(N_STEPS);
    localparam int PRE_N = TICKS_PER_US * STEP_US;
    localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam logic [W-1:0]     W_LAST   = W'(N_STEPS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);

    // Active-low {R,B,G} codes around the wheel, starting at RED.
    function automatic logic [2:0] wheel(input logic [2:0] i);
        case (i)
            3'd0:    return 3'b011;
            3'd1:    return 3'b010;
            3'd2:    return 3'b110;
            3'd3:    return 3'b100;
            3'd4:    return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i, input logic d);
        if (d) return (i == 3'd0) ? 3'd5 : i - 3'd1;
        else   return (i == 3'd5) ? 3'd0 : i + 3'd1;
    endfunction

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [W-1:0]     w_q, w_d;
    logic [2:0]       p_q, p_d;
    logic [2:0]       f_q, f_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       rev_q, rev_d;
    logic             tick;
    logic [2:0]       nxt;

    assign tick = bus.enable && !bus.hold && (pre_q == PRE_LAST);
    assign nxt  = next_idx(idx_q, dir_q);

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        w_d     = w_q;
        p_d     = p_q;
        f_d     = f_q;
        pulse_d = 1'b0;
        rev_d   = rev_q;

        // Restart wins over everything, including a coincident tick.
        if (bus.restart) begin
            pre_d   = '0;
            idx_d   = 3'd0;
            dir_d   = bus.dir;
            w_d     = '0;
            p_d     = wheel(3'd0);
            f_d     = wheel(next_idx(3'd0, bus.dir));
            pulse_d = 1'b1;
        end else begin
            if (!bus.enable) begin
                pre_d = '0;
            end else if (!bus.hold) begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
            end

            if (tick) begin
                pulse_d = 1'b1;
                if (w_q < W_LAST) begin
                    w_d = w_q + W'(1);
                end else begin
                    // Direction is only latched here so a transition never jumps mid-ramp.
                    w_d   = '0;
                    idx_d = nxt;
                    dir_d = bus.dir;
                    p_d   = wheel(nxt);
                    f_d   = wheel(next_idx(nxt, bus.dir));
                    if ((idx_q == 3'd5 && nxt == 3'd0) || (idx_q == 3'd0 && nxt == 3'd5))
                        rev_d = rev_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            idx_q   <= 3'd0;
            dir_q   <= 1'b0;
            w_q     <= '0;
            p_q     <= 3'b011;
            f_q     <= 3'b010;
            pulse_q <= 1'b0;
            rev_q   <= 8'd0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            w_q     <= w_d;
            p_q     <= p_d;
            f_q     <= f_d;
            pulse_q <= pulse_d;
            rev_q   <= rev_d;
        end
    end

    assign bus.p_color    = p_q;
    assign bus.f_color    = f_q;
    assign bus.f_weight   = w_q;
    assign bus.step_pulse = pulse_q;
    assign bus.rev_count  = rev_q;
endmodule

// File: tb/tb_rainbow_hue_sequencer.sv
// Directed plus randomized bench for the hue sequencer, checked against a
// wheel-position reference model.
module tb_rainbow_hue_sequencer;
    localparam int TPU   = 1;
    localparam int SUS   = 4;
    localparam int NS    = 4;
    localparam int PRE_N = TPU * SUS;
    localparam logic [2:0] WHEEL [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rainbow_hue_sequencer_if #(.N_STEPS(NS)) bus ();

    rainbow_hue_sequencer #(.TICKS_PER_US(TPU), .STEP_US(SUS), .N_STEPS(NS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: wheel position, ramp position, prescaler phase, latched direction.
    int m_pre, m_w, m_pos, m_dir, m_rev, m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_w = 0; m_pos = 0; m_dir = 0; m_rev = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit tk;
        if (!rst_n) begin
            model_reset();
        end else if (bus.restart) begin
            m_pos = 0; m_w = 0; m_pre = 0; m_dir = int'(bus.dir); m_pulse = 1;
        end else begin
            m_pulse = 0;
            tk = 0;
            if (!bus.enable) m_pre = 0;
            else if (!bus.hold) begin
                if (m_pre == PRE_N - 1) begin m_pre = 0; tk = 1; end
                else m_pre++;
            end
            if (tk) begin
                m_pulse = 1;
                if (m_w < NS - 1) m_w++;
                else begin
                    m_w = 0;
                    nxt = (m_pos + (m_dir ? 5 : 1)) % 6;
                    if ((m_pos == 5 && nxt == 0) || (m_pos == 0 && nxt == 5))
                        m_rev = (m_rev + 1) % 256;
                    m_pos = nxt;
                    m_dir = int'(bus.dir);
                end
            end
        end
    endtask

    task automatic check_model();
        chk("p_color",    32'(bus.p_color),    32'(WHEEL[m_pos]));
        chk("f_color",    32'(bus.f_color),    32'(WHEEL[(m_pos + (m_dir ? 5 : 1)) % 6]));
        chk("f_weight",   32'(bus.f_weight),   32'(m_w));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_pulse));
        chk("rev_count",  32'(bus.rev_count),  32'(m_rev));
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_model();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rev_before;
        bus.enable = 0; bus.hold = 0; bus.dir = 0; bus.restart = 0;
        model_reset();
        #23;
        chk("rst_p",     32'(bus.p_color),    32'h3);
        chk("rst_f",     32'(bus.f_color),    32'h2);
        chk("rst_w",     32'(bus.f_weight),   32'h0);
        chk("rst_pulse", 32'(bus.step_pulse), 32'h0);
        chk("rst_rev",   32'(bus.rev_count),  32'h0);
        @(negedge clk);
        rst_n = 1;

        // Forward run from RED.
        bus.enable = 1;
        cyc(3);
        chk("t1_early_pulse", 32'(bus.step_pulse), 32'h0);
        cyc(1);
        chk("t1_pulse", 32'(bus.step_pulse), 32'h1);
        chk("t1_w",     32'(bus.f_weight),   32'h1);
        chk("t1_p",     32'(bus.p_color),    32'h3);
        cyc(12);
        chk("t2_w", 32'(bus.f_weight), 32'h0);
        chk("t2_p", 32'(bus.p_color),  32'h2);
        chk("t2_f", 32'(bus.f_color),  32'h6);
        cyc(80);
        chk("t2_wrap_p",   32'(bus.p_color),   32'h3);
        chk("t2_wrap_f",   32'(bus.f_color),   32'h2);
        chk("t2_wrap_rev", 32'(bus.rev_count), 32'h1);

        // Direction change mid-transition.
        cyc(8);
        bus.dir = 1;
        cyc(7);
        chk("t3_f_held", 32'(bus.f_color), 32'h2);
        cyc(1);
        chk("t3_p1", 32'(bus.p_color), 32'h2);
        chk("t3_f1", 32'(bus.f_color), 32'h3);
        cyc(16);
        chk("t3_p2",   32'(bus.p_color),   32'h3);
        chk("t3_f2",   32'(bus.f_color),   32'h1);
        chk("t3_rev2", 32'(bus.rev_count), 32'h1);
        cyc(16);
        chk("t3_rev3", 32'(bus.rev_count), 32'h2);
        chk("t3_p3",   32'(bus.p_color),   32'h1);

        // Hold and enable gating of the prescaler.
        cyc(2);
        bus.hold = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("t4_hold_pulse", 32'(bus.step_pulse), 32'h0);
        end
        bus.hold = 0;
        cyc(1);
        chk("t4_after_hold0", 32'(bus.step_pulse), 32'h0);
        cyc(1);
        chk("t4_after_hold1", 32'(bus.step_pulse), 32'h1);
        cyc(1);
        bus.enable = 0;
        cyc(3);
        bus.enable = 1;
        cyc(3);
        chk("t4_after_en0", 32'(bus.step_pulse), 32'h0);
        cyc(1);
        chk("t4_after_en1", 32'(bus.step_pulse), 32'h1);

        // Restart coincident with a tick at idx=3, f_weight=2.
        bus.dir = 0;
        bus.restart = 1;
        cyc(1);
        bus.restart = 0;
        chk("t5_rs_p", 32'(bus.p_color), 32'h3);
        cyc(56);
        chk("t5_pre_p", 32'(bus.p_color),  32'h4);
        chk("t5_pre_w", 32'(bus.f_weight), 32'h2);
        cyc(3);
        rev_before = int'(bus.rev_count);
        bus.restart = 1;
        cyc(1);
        bus.restart = 0;
        chk("t5_p",     32'(bus.p_color),    32'h3);
        chk("t5_w",     32'(bus.f_weight),   32'h0);
        chk("t5_pulse", 32'(bus.step_pulse), 32'h1);
        chk("t5_rev",   32'(bus.rev_count),  32'(rev_before));
        cyc(3);
        chk("t5_gap", 32'(bus.step_pulse), 32'h0);
        cyc(1);
        chk("t5_next", 32'(bus.step_pulse), 32'h1);

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.restart = ($urandom_range(0, 99) < 2);
            bus.enable  = ($urandom_range(0, 19) != 0);
            bus.hold    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
            cyc(1);
        end
        bus.restart = 0; bus.enable = 1; bus.hold = 0;
        cyc(7);

        // Asynchronous reset between edges.
        #2;
        rst_n = 0;
        #1;
        chk("t6_p",     32'(bus.p_color),    32'h3);
        chk("t6_f",     32'(bus.f_color),    32'h2);
        chk("t6_w",     32'(bus.f_weight),   32'h0);
        chk("t6_pulse", 32'(bus.step_pulse), 32'h0);
        chk("t6_rev",   32'(bus.rev_count),  32'h0);
        model_reset();
        cyc(6);
        @(negedge clk);
        rst_n = 1;
        cyc(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
